sd_block_responder: RTL and testbench
=====================================

Name: sd_block_responder

Overview:
- Serves the target end of the MiSTer block-level SD interface: `sd_rd`/`sd_wr`/`sd_lba` requests in, `sd_ack`/`sd_buff_*` traffic out.
- Backs each request with a byte-wide memory port (SDRAM arbiter slot or simulation memory) holding a mounted disk image.
- Lets the SDC and floppy controllers run in sim and in HPS-less builds without the ARM side.
- One request is in flight at a time; each request moves one 512-byte sector.

Parameters:
- ACK_DELAY, 4: cycles from accepted request to `sd_ack` assertion (1..15).
- MEM_AW, 32: width of the byte address on the memory port.

Ports:
- clock  in  1  system clock; all logic on posedge
- RESET_N  in  1  asynchronous reset, active-low
- sd_lba  in  32  sector number, sampled on request edge
- sd_rd  in  1  read request (level; rising edge starts a transfer)
- sd_wr  in  1  write request (level; rising edge starts a transfer)
- sd_ack  out  1  high for the whole transfer
- sd_buff_addr  out  9  sector byte index
- sd_buff_dout  out  8  read data to initiator buffer
- sd_buff_wr  out  1  strobe for sd_buff_dout/sd_buff_addr
- sd_buff_din  in  8  write data from initiator buffer; valid 1 cycle after sd_buff_addr
- img_mounted  in  1  image present
- img_size  in  32  image size in bytes
- mem_addr  out  MEM_AW  byte address = {sd_lba[MEM_AW-10:0], index}
- mem_rd  out  1  read request, held until mem_ready
- mem_wr  out  1  write request, held until mem_ready
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data, valid with mem_ready
- mem_ready  in  1  completes a mem_rd/mem_wr in that cycle
- err  out  1  sticky: last request out of range or unmounted

Behaviour:
- Reset (async): every output 0, state IDLE, index 0, edge registers 0.
- Edges: `sd_rd_d`/`sd_wr_d` registered every cycle. Requests are accepted only in IDLE.
- Simultaneous rising edges: the read wins and the write edge is discarded; a write needs a fresh rising edge.
- On accept:
  - Latch lba and direction; clear `err`.
  - Set `oor` = (~img_mounted) | (lba >= img_size[31:9]). A partial trailing sector counts as out of range.
  - If `oor`, set `err`.
- States:
  - IDLE -> DLY on accept.
  - DLY: count ACK_DELAY cycles, then set `sd_ack` = 1, index = 0, go to RD_REQ (read) or WR_ADR (write).
  - RD_REQ: assert `mem_rd` with the address; hold until `mem_ready`, then capture `mem_rdata`. If `oor`, skip memory and use 8'h00. Go to RD_PUT.
  - RD_PUT: one cycle with `sd_buff_wr` = 1, `sd_buff_addr` = index, `sd_buff_dout` = captured byte. If index == 511 go to DONE; else index+1 and go to RD_REQ.
  - WR_ADR: drive `sd_buff_addr` = index, go to WR_LAT.
  - WR_LAT: capture `sd_buff_din` into `mem_wdata`, go to WR_MEM.
  - WR_MEM: assert `mem_wr` until `mem_ready`; if `oor`, no `mem_wr` and complete immediately. If index == 511 go to DONE; else index+1 and go to WR_ADR.
  - DONE: `sd_ack` = 0, go to IDLE.
- `sd_buff_wr` is asserted only while `sd_ack` = 1. The final strobe (addr 511) coincides with `sd_ack` = 1, and `sd_ack` drops the next cycle.
- `sd_buff_addr` holds its last value when not strobing.
- `mem_rd` and `mem_wr` are never high together. `mem_addr`/`mem_wdata` are stable while a request is held.
- Index arithmetic is 9-bit; no wrap past 511 is reachable.
- Mid-transfer: changes on img_mounted, img_size, sd_lba, sd_rd or sd_wr are ignored until IDLE.
- Reset mid-transfer: immediate return to reset values, with no partial `mem_wr` completion guaranteed.
- Latency (`mem_ready` tied 1):
  - Read: ACK_DELAY + 1 + 2×512 cycles from accept to `sd_ack` fall.
  - Write: ACK_DELAY + 1 + 3×512.

Test Plan:
- Reset: hold RESET_N low with sd_rd = 1 -> all outputs 0; after release no transfer starts until sd_rd toggles low→high.
- Read: img_size = 32'h0001_0000, memory byte[a] = a[7:0]^8'h5A, sd_lba = 3, sd_rd pulse -> sd_ack rises ACK_DELAY+1 cycles later; 512 strobes, addr 0..511, dout = (12'h600+i)[7:0]^8'h5A; sd_ack falls after addr 511; err = 0.
- Write: initiator buffer = i[7:0]^8'hA5, sd_lba = 1 -> 512 mem_wr at 0x200..0x3FF with matching data; no sd_buff_wr pulses.
- Stall: mem_ready random 25% duty during read -> identical data and order; mem_rd held stable across stall cycles.
- Out-of-range: img_size = 32'h400, sd_lba = 2 read -> 512 strobes of 8'h00, no mem_rd, err = 1; a following valid request clears err.
- Collision/reset: sd_rd and sd_wr rise together -> read executes, no mem_wr; RESET_N low at index 100 -> sd_ack = 0 asynchronously and the next read starts cleanly from index 0.

Source files
------------

// File: rtl/sd_block_responder_if.sv
// rtl/sd_block_responder_if.sv - block-level SD request/buffer bus plus byte-wide memory port
//
// Groups everything between the SD initiator, the image backing memory and the
// responder. The slave modport is the responder's view; master is the view of
// whatever surrounds it (initiator, memory, mount logic).
//   sd_lba/sd_rd/sd_wr        request from initiator
//   sd_ack                    high for the whole transfer
//   sd_buff_addr/dout/wr/din  sector buffer traffic
//   img_mounted/img_size      mounted image description
//   mem_*                     byte memory port, mem_ready completes a request
//   err                       sticky out-of-range/unmounted flag
interface sd_block_responder_if #(
  parameter int MEM_AW = 32
);
  logic [31:0]       sd_lba;
  logic              sd_rd;
  logic              sd_wr;
  logic              sd_ack;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic              sd_buff_wr;
  logic [7:0]        sd_buff_din;
  logic              img_mounted;
  logic [31:0]       img_size;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ready;
  logic              err;

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din, img_mounted, img_size,
           mem_rdata, mem_ready,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
           mem_addr, mem_rd, mem_wr, mem_wdata, err
  );

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din, img_mounted, img_size,
           mem_rdata, mem_ready,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
           mem_addr, mem_rd, mem_wr, mem_wdata, err
  );
endinterface

// File: rtl/sd_block_responder.sv
// rtl/sd_block_responder.sv - target end of the block-level SD interface backed by byte memory
//
// Serves one 512-byte sector per sd_rd/sd_wr rising edge from a mounted disk
// image held in a byte-wide memory. Reads move memory bytes into the initiator
// buffer via sd_buff_wr strobes; writes fetch buffer bytes and issue mem_wr.
// Requests beyond the image (or with no image) complete with zero data / no
// memory writes and raise the sticky err flag.
// Ports:
//   clock    system clock, posedge
//   RESET_N  asynchronous active-low reset
//   bus      sd_block_responder_if.slave (request, buffer, memory, err)
module sd_block_responder #(
  parameter int ACK_DELAY = 4,
  parameter int MEM_AW    = 32
) (
  input  logic                clock,
  input  logic                RESET_N,
  sd_block_responder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, DLY, RD_REQ, RD_PUT, WR_ADR, WR_LAT, WR_MEM, DONE
  } state_t;

  state_t             state;
  logic               sd_rd_d;
  logic               sd_wr_d;
  logic               primed;
  logic [MEM_AW-10:0] lba;
  logic               is_write;
  logic               oor;
  logic [3:0]         dly_cnt;
  logic [8:0]         index;
  logic [7:0]         rd_byte;

  logic               rd_edge;
  logic               wr_edge;
  logic               oor_now;
  logic [8:0]         next_index;

  // A level held high through reset must not look like a fresh request, so
  // edges only count once the edge registers have sampled one real cycle.
  assign rd_edge    = primed & bus.sd_rd & ~sd_rd_d;
  assign wr_edge    = primed & bus.sd_wr & ~sd_wr_d;
  // A partial trailing sector is treated as outside the image.
  assign oor_now    = ~bus.img_mounted | (bus.sd_lba >= (bus.img_size >> 9));
  assign next_index = index + 9'd1;

  function automatic logic [MEM_AW-1:0] addr_at(input logic [8:0] idx);
    return {lba, idx};
  endfunction

  always_ff @(posedge clock or negedge RESET_N) begin
    if (!RESET_N) begin
      state            <= IDLE;
      sd_rd_d          <= 1'b0;
      sd_wr_d          <= 1'b0;
      primed           <= 1'b0;
      lba              <= '0;
      is_write         <= 1'b0;
      oor              <= 1'b0;
      dly_cnt          <= 4'd0;
      index            <= 9'd0;
      rd_byte          <= 8'd0;
      bus.sd_ack       <= 1'b0;
      bus.sd_buff_addr <= 9'd0;
      bus.sd_buff_dout <= 8'd0;
      bus.sd_buff_wr   <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_rd       <= 1'b0;
      bus.mem_wr       <= 1'b0;
      bus.mem_wdata    <= 8'd0;
      bus.err          <= 1'b0;
    end else begin
      sd_rd_d        <= bus.sd_rd;
      sd_wr_d        <= bus.sd_wr;
      primed         <= 1'b1;
      bus.sd_buff_wr <= 1'b0;

      case (state)
        IDLE: begin
          // Read wins a simultaneous edge; the write edge is simply lost.
          if (rd_edge || wr_edge) begin
            lba      <= bus.sd_lba[MEM_AW-10:0];
            is_write <= ~rd_edge;
            oor      <= oor_now;
            bus.err  <= oor_now;
            dly_cnt  <= 4'd0;
            state    <= DLY;
          end
        end

        DLY: begin
          if (dly_cnt == 4'(ACK_DELAY - 1)) begin
            bus.sd_ack <= 1'b1;
            index      <= 9'd0;
            if (is_write) begin
              bus.sd_buff_addr <= 9'd0;
              state            <= WR_ADR;
            end else begin
              bus.mem_addr <= addr_at(9'd0);
              bus.mem_rd   <= ~oor;
              state        <= RD_REQ;
            end
          end else begin
            dly_cnt <= dly_cnt + 4'd1;
          end
        end

        RD_REQ: begin
          if (oor) begin
            rd_byte <= 8'h00;
            state   <= RD_PUT;
          end else if (bus.mem_ready) begin
            rd_byte    <= bus.mem_rdata;
            bus.mem_rd <= 1'b0;
            state      <= RD_PUT;
          end
        end

        RD_PUT: begin
          bus.sd_buff_wr   <= 1'b1;
          bus.sd_buff_addr <= index;
          bus.sd_buff_dout <= rd_byte;
          if (index == 9'd511) begin
            state <= DONE;
          end else begin
            index        <= next_index;
            bus.mem_addr <= addr_at(next_index);
            bus.mem_rd   <= ~oor;
            state        <= RD_REQ;
          end
        end

        // sd_buff_addr is already presented; the buffer answers a cycle later.
        WR_ADR: state <= WR_LAT;

        WR_LAT: begin
          bus.mem_wdata <= bus.sd_buff_din;
          bus.mem_addr  <= addr_at(index);
          bus.mem_wr    <= ~oor;
          state         <= WR_MEM;
        end

        WR_MEM: begin
          if (oor || bus.mem_ready) begin
            bus.mem_wr <= 1'b0;
            if (index == 9'd511) begin
              state <= DONE;
            end else begin
              index            <= next_index;
              bus.sd_buff_addr <= next_index;
              state            <= WR_ADR;
            end
          end
        end

        DONE: begin
          bus.sd_ack <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_block_responder.sv
// tb/tb_sd_block_responder.sv - self-checking bench for sd_block_responder
module tb_sd_block_responder;
  localparam int ACK_DELAY = 4;
  localparam int MEM_AW    = 32;

  logic clock = 1'b0;
  logic RESET_N = 1'b0;
  always #5 clock = ~clock;

  sd_block_responder_if #(.MEM_AW(MEM_AW)) bus ();

  sd_block_responder #(.ACK_DELAY(ACK_DELAY), .MEM_AW(MEM_AW)) dut (
    .clock   (clock),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } exp_t;

  typedef struct {
    logic        rd;
    logic        wr_too;
    logic [31:0] lba;
    logic [31:0] size;
    logic        mounted;
    logic        stall;
    logic        exp_err;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[8];

  int checks = 0;
  int failures = 0;
  int n_strobe = 0;
  int n_memwr = 0;
  int n_memrd = 0;
  int rd_base = 0;
  logic        stall = 1'b0;
  logic [31:0] cur_lba = 32'd0;
  logic [8:0]  buf_addr_q = 9'd0;
  logic        hold_prev = 1'b0;
  logic        hold_is_rd = 1'b0;
  logic [31:0] hold_addr = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Memory and initiator-buffer models plus the output monitor. Inputs for the
  // coming posedge are driven first, then the outputs that the same posedge
  // will act on are inspected.
  always @(negedge clock) begin : model
    exp_t        e;
    logic [31:0] ea;
    int          k;
    bus.mem_ready   = stall ? ($urandom_range(0, 3) == 0) : 1'b1;
    bus.mem_rdata   = bus.mem_addr[7:0] ^ 8'h5A;
    bus.sd_buff_din = buf_addr_q[7:0] ^ 8'hA5;   // one cycle behind the address
    buf_addr_q      = bus.sd_buff_addr;
    if (RESET_N) begin
      if (hold_prev) begin
        check("mem_req_held", {31'd0, hold_is_rd ? bus.mem_rd : bus.mem_wr}, 32'd1);
        check("mem_addr_stable", bus.mem_addr, hold_addr);
      end
      check("rd_wr_exclusive", {31'd0, bus.mem_rd & bus.mem_wr}, 32'd0);
      if (bus.sd_buff_wr) begin
        n_strobe++;
        check("strobe_inside_ack", {31'd0, bus.sd_ack}, 32'd1);
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_strobe: got addr 0x%0h required no strobe", bus.sd_buff_addr);
        end else begin
          e = sb_q.pop_front();
          check("strobe_addr", {23'd0, bus.sd_buff_addr}, e.addr);
          check("strobe_data", {24'd0, bus.sd_buff_dout}, {24'd0, e.data});
        end
      end
      if (bus.mem_rd && bus.mem_ready) begin
        k  = n_memrd - rd_base;
        ea = {cur_lba[MEM_AW-10:0], 9'(k)};
        check("mem_rd_addr", bus.mem_addr, ea);
        n_memrd++;
      end
      if (bus.mem_wr && bus.mem_ready) begin
        n_memwr++;
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_mem_wr: got addr 0x%0h required no write", bus.mem_addr);
        end else begin
          e = sb_q.pop_front();
          check("mem_wr_addr", bus.mem_addr, e.addr);
          check("mem_wr_data", {24'd0, bus.mem_wdata}, {24'd0, e.data});
        end
      end
      hold_prev  = (bus.mem_rd || bus.mem_wr) && !bus.mem_ready;
      hold_is_rd = bus.mem_rd;
      hold_addr  = bus.mem_addr;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic push_expect(input vec_t v);
    exp_t e;
    for (int i = 0; i < 512; i++) begin
      if (v.rd) begin
        e.addr = 32'(i);
        e.data = v.exp_err ? 8'h00 : (8'(i) ^ 8'h5A);
        sb_q.push_back(e);
      end else if (!v.exp_err) begin
        e.addr = {v.lba[MEM_AW-10:0], 9'(i)};
        e.data = 8'(i) ^ 8'hA5;
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic start_req(input vec_t v);
    @(negedge clock);
    bus.sd_lba      = v.lba;
    bus.img_size    = v.size;
    bus.img_mounted = v.mounted;
    stall           = v.stall;
    cur_lba         = v.lba;
    rd_base         = n_memrd;
    push_expect(v);
    if (v.rd) bus.sd_rd = 1'b1;
    if (!v.rd || v.wr_too) bus.sd_wr = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int n = 0;
    int s0, w0, r0;
    s0 = n_strobe; w0 = n_memwr; r0 = n_memrd;
    start_req(v);
    while (!bus.sd_ack && n < 100) begin
      @(posedge clock); #1; n++;
    end
    check("ack_delay", n, ACK_DELAY + 1);
    while (bus.sd_ack && n < 20000) begin
      @(posedge clock); #1; n++;
    end
    if (!v.stall) check("xfer_cycles", n, ACK_DELAY + 2 + (v.rd ? 2 : 3) * 512);
    else          check("ack_fell", {31'd0, bus.sd_ack}, 32'd0);
    check("err", {31'd0, bus.err}, {31'd0, v.exp_err});
    check("strobe_count", n_strobe - s0, v.rd ? 512 : 0);
    check("mem_wr_count", n_memwr - w0, (!v.rd && !v.exp_err) ? 512 : 0);
    check("mem_rd_count", n_memrd - r0, (v.rd && !v.exp_err) ? 512 : 0);
    check("sb_empty", sb_q.size(), 0);
    @(negedge clock);
    bus.sd_rd = 1'b0;
    bus.sd_wr = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n;
    int s0;
    //           rd    wr_too lba     size          mnt   stall err
    tbl[0] = '{1'b1, 1'b0, 32'd3, 32'h0001_0000, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 32'd1, 32'h0001_0000, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 32'd3, 32'h0001_0000, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 32'd2, 32'h0000_0400, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 32'd0, 32'h0000_0400, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 32'd0, 32'h0001_0000, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 32'd2, 32'h0000_05FF, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 32'd5, 32'h0001_0000, 1'b1, 1'b0, 1'b0};

    bus.sd_rd       = 1'b1;
    bus.sd_wr       = 1'b0;
    bus.sd_lba      = 32'd3;
    bus.img_size    = 32'h0001_0000;
    bus.img_mounted = 1'b1;
    RESET_N         = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_sd_ack", {31'd0, bus.sd_ack}, 32'd0);
    check("rst_buff_wr", {31'd0, bus.sd_buff_wr}, 32'd0);
    check("rst_buff_addr", {23'd0, bus.sd_buff_addr}, 32'd0);
    check("rst_buff_dout", {24'd0, bus.sd_buff_dout}, 32'd0);
    check("rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    check("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    RESET_N = 1'b1;
    repeat (12) @(negedge clock);
    check("held_rd_no_ack", {31'd0, bus.sd_ack}, 32'd0);
    check("held_rd_no_mem", n_memrd, 0);
    bus.sd_rd = 1'b0;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // Reset in the middle of a read, once index 100 has been strobed.
    s0 = n_strobe;
    start_req(tbl[0]);
    n = 0;
    while ((n_strobe - s0) < 101 && n < 5000) begin
      @(posedge clock); #1; n++;
    end
    check("reached_index_100", n_strobe - s0 >= 101, 1);
    #1 RESET_N = 1'b0;
    #1;
    check("midreset_ack", {31'd0, bus.sd_ack}, 32'd0);
    check("midreset_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    check("midreset_buff_wr", {31'd0, bus.sd_buff_wr}, 32'd0);
    sb_q.delete();
    bus.sd_rd = 1'b0;
    repeat (3) @(negedge clock);
    RESET_N = 1'b1;
    repeat (3) @(negedge clock);
    run_vec(tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
